mem_request_ctrl: RTL and testbench

Parametrised successor to the datapath request unit for the multicycle-memory MIPS core. Sequences instruction fetch and data access requests onto the shared memory port. Holds each data request until the memory acknowledges it and gates PC advance accordingly. Handles halt draining and provides a data-wait watchdog. Sits between control unit/datapath and the memory controller/cache interface.

---
 rtl/req_unit_pkg.sv | 14 +
 rtl/mem_request_ctrl_if.sv | 43 ++++
 rtl/sat_counter.sv | 23 ++
 rtl/mem_request_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_request_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/req_unit_pkg.sv
// rtl/req_unit_pkg.sv - shared types and defaults for the memory request controller
package req_unit_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DATA = 2'd1,
    HALT = 2'd2
  } reqstate_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;
  localparam int CNT_W_DEFAULT          = 16;
  localparam int PERF_W_DEFAULT         = 32;

endpackage

// File: rtl/mem_request_ctrl_if.sv
// rtl/mem_request_ctrl_if.sv - request unit handshake bundle (perf counters with REQUNIT_PERF_EN)
interface mem_request_ctrl_if
`ifdef REQUNIT_PERF_EN
  #(parameter int PERF_W = req_unit_pkg::PERF_W_DEFAULT)
`endif
  ();

  logic halt;
  logic ihit;
  logic dhit;
  logic dREN;
  logic dWEN;
  logic imemREN;
  logic dmemREN;
  logic dmemWEN;
  logic pcWEN;
  logic busy;
  logic halted;
  logic timeout;
`ifdef REQUNIT_PERF_EN
  logic [PERF_W-1:0] icyc_stall;
  logic [PERF_W-1:0] dcyc_stall;
`endif

  // Controller side: consumes decode/memory acknowledges, drives requests.
  modport master (
    input  halt, ihit, dhit, dREN, dWEN,
    output imemREN, dmemREN, dmemWEN, pcWEN, busy, halted, timeout
`ifdef REQUNIT_PERF_EN
    , output icyc_stall, dcyc_stall
`endif
  );

  // Datapath / memory side.
  modport slave (
    output halt, ihit, dhit, dREN, dWEN,
    input  imemREN, dmemREN, dmemWEN, pcWEN, busy, halted, timeout
`ifdef REQUNIT_PERF_EN
    , input icyc_stall, dcyc_stall
`endif
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_request_ctrl.sv
// rtl/mem_request_ctrl.sv - fetch/data request sequencer with halt drain and watchdog (REQUNIT_PERF_EN adds stall counters)
import req_unit_pkg::*;

module mem_request_ctrl #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = CNT_W_DEFAULT
`ifdef REQUNIT_PERF_EN
  , parameter int PERF_W       = PERF_W_DEFAULT
`endif
) (
  input  logic            CLK,
  input  logic            RST,
  mem_request_ctrl_if.master bus
);

  reqstate_t state;
  reqstate_t state_next;
  logic      dmem_ren_q;
  logic      dmem_wen_q;
  logic      dmem_ren_next;
  logic      dmem_wen_next;
  logic      imem_ren;
  logic      pc_wen;
  logic      data_req;
  logic      start_data;

  assign data_req   = bus.dREN | bus.dWEN;
  assign start_data = (state == RUN) && bus.ihit && data_req;

  // State and the registered data-memory enables; reset drops the enables at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= RUN;
      dmem_ren_q <= 1'b0;
      dmem_wen_q <= 1'b0;
    end else begin
      state      <= state_next;
      dmem_ren_q <= dmem_ren_next;
      dmem_wen_q <= dmem_wen_next;
    end
  end

  // Next state, enable capture and the combinational fetch/PC controls.
  always_comb begin
    state_next    = state;
    dmem_ren_next = dmem_ren_q;
    dmem_wen_next = dmem_wen_q;
    imem_ren      = 1'b0;
    pc_wen        = 1'b0;
    unique case (state)
      RUN: begin
        imem_ren = 1'b1;
        pc_wen   = bus.ihit & ~data_req & ~bus.halt;
        if (bus.ihit && data_req) begin
          state_next    = DATA;
          dmem_wen_next = bus.dWEN;
          dmem_ren_next = bus.dREN & ~bus.dWEN;
        end else if (bus.ihit && bus.halt) begin
          state_next = HALT;
        end
      end
      DATA: begin
        pc_wen = bus.dhit;
        if (bus.dhit) begin
          dmem_ren_next = 1'b0;
          dmem_wen_next = 1'b0;
          state_next    = bus.halt ? HALT : RUN;
        end
      end
      HALT: begin
        dmem_ren_next = 1'b0;
        dmem_wen_next = 1'b0;
      end
      default: begin
        state_next    = RUN;
        dmem_ren_next = 1'b0;
        dmem_wen_next = 1'b0;
      end
    endcase
  end

  assign bus.imemREN = imem_ren;
  assign bus.pcWEN   = pc_wen;
  assign bus.dmemREN = dmem_ren_q;
  assign bus.dmemWEN = dmem_wen_q;
  assign bus.busy    = (state == DATA);
  assign bus.halted  = (state == HALT);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_watchdog
      logic [CNT_W-1:0] wd_count;
      logic             timeout_q;

      sat_counter #(.WIDTH(CNT_W)) u_wd_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (start_data),
        .inc   ((state == DATA) && !bus.dhit),
        .count (wd_count)
      );

      // Sticky timeout once a data request has waited the full budget.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          timeout_q <= 1'b0;
        end else if ((state == DATA) && !bus.dhit &&
                     (wd_count == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          timeout_q <= 1'b1;
        end
      end

      assign bus.timeout = timeout_q;
    end else begin : g_no_watchdog
      assign bus.timeout = 1'b0;
    end
  endgenerate

`ifdef REQUNIT_PERF_EN
  sat_counter #(.WIDTH(PERF_W)) u_icyc_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (1'b0),
    .inc   (imem_ren & ~bus.ihit),
    .count (bus.icyc_stall)
  );

  sat_counter #(.WIDTH(PERF_W)) u_dcyc_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (1'b0),
    .inc   ((state == DATA) & ~bus.dhit),
    .count (bus.dcyc_stall)
  );
`endif

endmodule

// File: tb/tb_mem_request_ctrl.sv
// tb/tb_mem_request_ctrl.sv - self-checking bench for mem_request_ctrl
module tb_mem_request_ctrl;

  localparam int TMO = 8;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  mem_request_ctrl_if bus ();

  mem_request_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one outstanding data request at most, with its age.
  logic m_pend;
  logic m_wr;
  int   m_wait;
  logic m_halted;
  logic m_timeout;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pend    = 1'b0;
      m_wr      = 1'b0;
      m_wait    = 0;
      m_halted  = 1'b0;
      m_timeout = 1'b0;
    end else if (m_halted) begin
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (bus.dhit) begin
        m_pend = 1'b0;
        if (bus.halt) m_halted = 1'b1;
      end else begin
        m_wait = m_wait + 1;
        if (m_wait == TMO) m_timeout = 1'b1;
      end
    end else if (bus.ihit && (bus.dREN || bus.dWEN)) begin
      m_pend = 1'b1;
      m_wr   = bus.dWEN;
      m_wait = 0;
    end else if (bus.ihit && bus.halt) begin
      m_halted = 1'b1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge CLK) begin
    if (!RST) begin
      if (m_halted) begin
        check("m_imemREN", bus.imemREN, 0);
        check("m_dmemREN", bus.dmemREN, 0);
        check("m_dmemWEN", bus.dmemWEN, 0);
        check("m_pcWEN",   bus.pcWEN,   0);
        check("m_busy",    bus.busy,    0);
      end else if (m_pend) begin
        check("m_imemREN", bus.imemREN, 0);
        check("m_dmemREN", bus.dmemREN, {31'd0, ~m_wr});
        check("m_dmemWEN", bus.dmemWEN, {31'd0, m_wr});
        check("m_pcWEN",   bus.pcWEN,   {31'd0, bus.dhit});
        check("m_busy",    bus.busy,    1);
      end else begin
        check("m_imemREN", bus.imemREN, 1);
        check("m_dmemREN", bus.dmemREN, 0);
        check("m_dmemWEN", bus.dmemWEN, 0);
        check("m_pcWEN",   bus.pcWEN,
              {31'd0, bus.ihit & ~(bus.dREN | bus.dWEN) & ~bus.halt});
        check("m_busy",    bus.busy,    0);
      end
      check("m_halted",  bus.halted,  {31'd0, m_halted});
      check("m_timeout", bus.timeout, {31'd0, m_timeout});
    end
  end

  task automatic drive(input logic h, input logic ih, input logic dh,
                       input logic r, input logic w);
    bus.halt = h;
    bus.ihit = ih;
    bus.dhit = dh;
    bus.dREN = r;
    bus.dWEN = w;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    drive(0, 0, 0, 0, 0);
    #12;
    check("rst_dmemREN", bus.dmemREN, 0);
    check("rst_dmemWEN", bus.dmemWEN, 0);
    check("rst_halted",  bus.halted,  0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_busy",    bus.busy,    0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Plain fetches advance the PC every cycle.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0);
      #1;
      check("fetch_pcWEN",   bus.pcWEN,   1);
      check("fetch_imemREN", bus.imemREN, 1);
      tick();
    end

    // Load acknowledged on the fourth data cycle.
    drive(0, 1, 0, 1, 0);
    #1;
    check("load_issue_pcWEN", bus.pcWEN, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    check("load_dmemREN", bus.dmemREN, 1);
    check("load_imemREN", bus.imemREN, 0);
    check("load_busy",    bus.busy,    1);
    tick();
    tick();
    tick();
    drive(0, 0, 1, 0, 0);
    #1;
    check("load_dhit_pcWEN", bus.pcWEN, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    check("load_done_dmemREN", bus.dmemREN, 0);
    check("load_done_imemREN", bus.imemREN, 1);

    // Read and write together: write wins and is held.
    drive(0, 1, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    check("rw_dmemWEN", bus.dmemWEN, 1);
    check("rw_dmemREN", bus.dmemREN, 0);
    tick();
    tick();
    check("rw_hold_dmemWEN", bus.dmemWEN, 1);
    drive(0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);

    // halt without ihit is ignored.
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    check("halt_noihit_halted", bus.halted, 0);

    // Watchdog: timeout visible after TMO unacknowledged data cycles.
    drive(0, 1, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) tick();
    check("wd_before_timeout", bus.timeout, 0);
    tick();
    check("wd_timeout",      bus.timeout, 1);
    check("wd_still_dmemREN", bus.dmemREN, 1);
    drive(0, 0, 1, 0, 0);
    #1;
    check("wd_late_pcWEN", bus.pcWEN, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    check("wd_done_dmemREN", bus.dmemREN, 0);
    check("wd_sticky",       bus.timeout, 1);

    // Asynchronous reset in the middle of a store.
    drive(0, 1, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    check("rstmid_pre_dmemWEN", bus.dmemWEN, 1);
    #2;
    RST = 1'b1;
    #1;
    check("rstmid_dmemWEN", bus.dmemWEN, 0);
    check("rstmid_dmemREN", bus.dmemREN, 0);
    check("rstmid_timeout", bus.timeout, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check("rstmid_imemREN", bus.imemREN, 1);
    check("rstmid_busy",    bus.busy,    0);
    tick();

    // halt during an outstanding store drains it, then halts for good.
    drive(0, 1, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 0);
    #1;
    check("halt_store_dmemWEN", bus.dmemWEN, 1);
    check("halt_store_pcWEN",   bus.pcWEN,   0);
    tick();
    tick();
    drive(1, 0, 1, 0, 0);
    tick();
    drive(0, 1, 0, 1, 0);
    #1;
    check("halted_set",     bus.halted,  1);
    check("halted_imemREN", bus.imemREN, 0);
    for (int i = 0; i < 10; i++) tick();
    check("halted_stays",   bus.halted,  1);
    check("halted_dmemREN", bus.dmemREN, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
